// File: rtl/sdram_access_arbiter_if.sv
// 16-bit Avalon-MM SDRAM slave bus shared by the access arbiter.
// The master modport is the arbiter side, the slave modport the SDRAM controller side.
interface sdram_access_arbiter_if #(
  parameter int unsigned ADDR_BITS = 21
) ();
  logic [ADDR_BITS:0] address;
  logic [1:0]         byteenable_n;
  logic               chipselect;
  logic [15:0]        writedata;
  logic               read_n;
  logic               write_n;
  logic [15:0]        readdata;
  logic               waitrequest;
  logic               readdatavalid;

  modport master (
    output address, byteenable_n, chipselect, writedata, read_n, write_n,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable_n, chipselect, writedata, read_n, write_n,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/sdram_access_arbiter.sv
// Shares one 16-bit SDRAM slave port between the loader (write-only) and the MCU data port,
// splitting each 32-bit access into two halfword beats. Optional macro: SDRAM_ARB_ROUND_ROBIN_EN.
module sdram_access_arbiter #(
  parameter int unsigned ADDR_BITS  = 21,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] loader_mem_addr,
  input  logic                 loader_mem_write_en,
  input  logic [3:0]           loader_mem_byte_enable,
  input  logic [31:0]          loader_mem_write_data,
  output logic                 loader_ack,
  input  logic [ADDR_BITS-1:0] mcu_mem_addr,
  input  logic                 mcu_mem_read_en,
  input  logic                 mcu_mem_write_en,
  input  logic [3:0]           mcu_mem_byte_enable,
  input  logic [31:0]          mcu_mem_write_data,
  output logic [31:0]          mcu_mem_read_data,
  output logic                 mcu_ack,
  sdram_access_arbiter_if.master sdram_slave
);

  localparam int unsigned TMO_W           = $clog2(RD_TIMEOUT + 1);
  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT_RD, DONE} state_t;
  typedef enum logic {OWN_MCU = 1'b0, OWN_LOADER = 1'b1} owner_t;

  typedef struct packed {
    logic                 cs;
    logic                 read_n;
    logic                 write_n;
    logic [1:0]           be_n;
    logic [ADDR_BITS:0]   addr;
    logic [15:0]          data;
  } cmd_t;

  typedef struct packed {
    owner_t               owner;
    logic                 wr;
    logic [ADDR_BITS-1:0] addr;
    logic [3:0]           be;
    logic [31:0]          data;
  } req_t;

  localparam cmd_t CMD_RESET = '{cs: 1'b0, read_n: 1'b1, write_n: 1'b1, be_n: 2'b11,
                                 addr: '0, data: 16'h0000};

  state_t             state_q, state_d;
  req_t               req_q, req_d, new_req;
  cmd_t               cmd_q, cmd_d;
  logic [1:0]         rd_cnt_q, rd_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [15:0]        rd_lo_q, rd_lo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               loader_ack_q, loader_ack_d;
  logic               mcu_ack_q, mcu_ack_d;
  logic               loader_req, mcu_req, grant_loader, rd_strobe;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  owner_t             last_grant_q, last_grant_d;
`endif

  // Command for one halfword beat of a latched request; reads always enable both bytes.
  function automatic cmd_t beat_cmd(input req_t r, input logic hi);
    cmd_t c;
    c.cs      = 1'b1;
    c.read_n  = r.wr;
    c.write_n = ~r.wr;
    c.be_n    = r.wr ? ~(hi ? r.be[3:2] : r.be[1:0]) : 2'b00;
    c.addr    = {r.addr, hi};
    c.data    = hi ? r.data[31:16] : r.data[15:0];
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cmd_d        = cmd_q;
    cmd_d.cs     = 1'b0;
    cmd_d.read_n = 1'b1;
    cmd_d.write_n = 1'b1;
    cmd_d.be_n   = 2'b11;
    rd_cnt_d     = rd_cnt_q;
    tmo_d        = tmo_q;
    rd_lo_d      = rd_lo_q;
    rdata_d      = rdata_q;
    loader_ack_d = 1'b0;
    mcu_ack_d    = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    loader_req = loader_mem_write_en;
    mcu_req    = mcu_mem_read_en | mcu_mem_write_en;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    grant_loader = loader_req & (~mcu_req | (last_grant_q == OWN_MCU));
`else
    grant_loader = loader_req;
`endif

    // A simultaneous MCU read+write is served as a write.
    new_req.owner = grant_loader ? OWN_LOADER : OWN_MCU;
    new_req.wr    = grant_loader | mcu_mem_write_en;
    new_req.addr  = grant_loader ? loader_mem_addr        : mcu_mem_addr;
    new_req.be    = grant_loader ? loader_mem_byte_enable : mcu_mem_byte_enable;
    new_req.data  = grant_loader ? loader_mem_write_data  : mcu_mem_write_data;

    // Low-half data can return while the high beat is still stalled.
    rd_strobe = sdram_slave.readdatavalid & ~req_q.wr &
                ((state_q == ISSUE_HI) | (state_q == WAIT_RD));
    if (rd_strobe) begin
      if (rd_cnt_q == 2'd0) begin
        rd_lo_d  = sdram_slave.readdata;
        rd_cnt_d = 2'd1;
      end else if (rd_cnt_q == 2'd1) begin
        rdata_d  = {sdram_slave.readdata, rd_lo_q};
        rd_cnt_d = 2'd2;
      end
    end

    case (state_q)
      IDLE: begin
        if (loader_req | mcu_req) begin
          req_d = new_req;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          last_grant_d = new_req.owner;
`endif
          if (new_req.wr && (new_req.be[1:0] == 2'b00)) begin
            if (new_req.be[3:2] == 2'b00) begin
              state_d = DONE;
            end else begin
              state_d = ISSUE_HI;
              cmd_d   = beat_cmd(new_req, 1'b1);
            end
          end else begin
            state_d = ISSUE_LO;
            cmd_d   = beat_cmd(new_req, 1'b0);
          end
        end
      end
      ISSUE_LO: begin
        if (sdram_slave.waitrequest) begin
          cmd_d = cmd_q;
        end else if (!req_q.wr || (req_q.be[3:2] != 2'b00)) begin
          state_d = ISSUE_HI;
          cmd_d   = beat_cmd(req_q, 1'b1);
        end else begin
          state_d = DONE;
        end
      end
      ISSUE_HI: begin
        if (sdram_slave.waitrequest) begin
          cmd_d = cmd_q;
        end else if (req_q.wr) begin
          state_d = DONE;
        end else begin
          tmo_d   = '0;
          state_d = (rd_cnt_d == 2'd2) ? DONE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rd_cnt_d == 2'd2) begin
          state_d = DONE;
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          state_d = DONE;
          rdata_d = RD_TIMEOUT_DATA;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stale read strobes arriving in IDLE must not carry into the next read.
    if (state_d == IDLE) begin
      rd_cnt_d = 2'd0;
      tmo_d    = '0;
    end

    loader_ack_d = (state_d == DONE) && (req_d.owner == OWN_LOADER);
    mcu_ack_d    = (state_d == DONE) && (req_d.owner == OWN_MCU);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cmd_q        <= CMD_RESET;
      rd_cnt_q     <= 2'd0;
      tmo_q        <= '0;
      rd_lo_q      <= 16'h0000;
      rdata_q      <= 32'h0000_0000;
      loader_ack_q <= 1'b0;
      mcu_ack_q    <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= OWN_MCU;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cmd_q        <= cmd_d;
      rd_cnt_q     <= rd_cnt_d;
      tmo_q        <= tmo_d;
      rd_lo_q      <= rd_lo_d;
      rdata_q      <= rdata_d;
      loader_ack_q <= loader_ack_d;
      mcu_ack_q    <= mcu_ack_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign sdram_slave.chipselect   = cmd_q.cs;
  assign sdram_slave.read_n       = cmd_q.read_n;
  assign sdram_slave.write_n      = cmd_q.write_n;
  assign sdram_slave.byteenable_n = cmd_q.be_n;
  assign sdram_slave.address      = cmd_q.addr;
  assign sdram_slave.writedata    = cmd_q.data;
  assign loader_ack               = loader_ack_q;
  assign mcu_ack                  = mcu_ack_q;
  assign mcu_mem_read_data        = rdata_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter: SDRAM slave model plus a word-level
// reference memory; randomized accesses and directed corner scenarios.
module tb_sdram_access_arbiter;
  localparam int unsigned ADDR_BITS  = 21;
  localparam int unsigned RD_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [20:0] loader_mem_addr;
  logic        loader_mem_write_en;
  logic [3:0]  loader_mem_byte_enable;
  logic [31:0] loader_mem_write_data;
  logic        loader_ack;
  logic [20:0] mcu_mem_addr;
  logic        mcu_mem_read_en;
  logic        mcu_mem_write_en;
  logic [3:0]  mcu_mem_byte_enable;
  logic [31:0] mcu_mem_write_data;
  logic [31:0] mcu_mem_read_data;
  logic        mcu_ack;

  sdram_access_arbiter_if #(.ADDR_BITS(ADDR_BITS)) sd ();

  sdram_access_arbiter #(.ADDR_BITS(ADDR_BITS), .RD_TIMEOUT(RD_TIMEOUT)) u_dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .loader_mem_addr        (loader_mem_addr),
    .loader_mem_write_en    (loader_mem_write_en),
    .loader_mem_byte_enable (loader_mem_byte_enable),
    .loader_mem_write_data  (loader_mem_write_data),
    .loader_ack             (loader_ack),
    .mcu_mem_addr           (mcu_mem_addr),
    .mcu_mem_read_en        (mcu_mem_read_en),
    .mcu_mem_write_en       (mcu_mem_write_en),
    .mcu_mem_byte_enable    (mcu_mem_byte_enable),
    .mcu_mem_write_data     (mcu_mem_write_data),
    .mcu_mem_read_data      (mcu_mem_read_data),
    .mcu_ack                (mcu_ack),
    .sdram_slave            (sd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  be_n;
    logic [15:0] data;
    logic        wr;
  } log_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sd_mem [logic [21:0]];
  logic [31:0] ref_mem [logic [20:0]];
  log_t        cmd_log[$];
  log_t        exp_log[$];
  resp_t       resp_q[$];
  int          stall_q[$];
  int          rd_lat = 4;
  bit          drop_reads = 1'b0;
  bit          inject_late = 1'b0;
  int          cyc = 0;

  // SDRAM controller model: per-command stall plan, byte-masked writes, delayed read returns.
  initial begin : sdram_model
    bit          in_cmd;
    int          stall_cnt, target;
    logic [41:0] snap, cur;
    logic [15:0] hw;
    log_t        e;
    in_cmd = 1'b0; stall_cnt = 0; target = 0; snap = '0;
    sd.waitrequest = 1'b0; sd.readdatavalid = 1'b0; sd.readdata = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (inject_late) begin
        sd.readdatavalid = 1'b1; sd.readdata = 16'hFFFF; inject_late = 1'b0;
      end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        sd.readdatavalid = 1'b1; sd.readdata = resp_q[0].data; void'(resp_q.pop_front());
      end else begin
        sd.readdatavalid = 1'b0;
      end
      cur = {sd.read_n, sd.write_n, sd.byteenable_n, sd.address, sd.writedata};
      if (sd.chipselect === 1'b1) begin
        if (!in_cmd) begin
          in_cmd = 1'b1; stall_cnt = 0; snap = cur;
          target = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        end else begin
          n_cmp++;
          if (cur !== snap) begin
            n_err++;
            $display("FAIL stall_hold: command %h changed during waitrequest, required %h", cur, snap);
          end
        end
        if (stall_cnt < target) begin
          sd.waitrequest = 1'b1; stall_cnt++;
        end else begin
          sd.waitrequest = 1'b0; in_cmd = 1'b0;
          e = '{addr: sd.address, be_n: sd.byteenable_n, data: sd.writedata, wr: ~sd.write_n};
          cmd_log.push_back(e);
          hw = sd_mem.exists(sd.address) ? sd_mem[sd.address] : 16'h0;
          if (sd.write_n === 1'b0) begin
            if (!sd.byteenable_n[0]) hw[7:0]  = sd.writedata[7:0];
            if (!sd.byteenable_n[1]) hw[15:8] = sd.writedata[15:8];
            sd_mem[sd.address] = hw;
          end else if (!drop_reads) begin
            resp_q.push_back('{due: cyc + rd_lat, data: hw});
          end
        end
      end else begin
        sd.waitrequest = 1'b0; in_cmd = 1'b0;
      end
    end
  end

  // Expected SDRAM commands for one 32-bit access: low half first, all-zero write halves skipped.
  task automatic build_exp(input bit wr, input logic [20:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    exp_log.delete();
    for (int h = 0; h < 2; h++) begin
      logic [1:0]  hb;
      logic [15:0] hd;
      hb = (h == 1) ? be[3:2] : be[1:0];
      hd = (h == 1) ? d[31:16] : d[15:0];
      if (!wr) exp_log.push_back('{addr: {a, 1'(h)}, be_n: 2'b00, data: 16'h0, wr: 1'b0});
      else if (hb != 2'b00) exp_log.push_back('{addr: {a, 1'(h)}, be_n: ~hb, data: hd, wr: 1'b1});
    end
  endtask

  function automatic int log_diff();
    if (cmd_log.size() != exp_log.size()) return -2;
    for (int i = 0; i < exp_log.size(); i++) begin
      if (exp_log[i].wr ? (cmd_log[i] !== exp_log[i])
                        : ({cmd_log[i].addr, cmd_log[i].be_n, cmd_log[i].wr} !==
                           {exp_log[i].addr, exp_log[i].be_n, exp_log[i].wr}))
        return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic ref_write(input logic [20:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = ref_read(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endtask

  // Drives one request and waits (bounded) for the owner's ack; inputs are scrambled once owned.
  task automatic do_txn(input bit ldr, input bit wr, input bit both, input logic [20:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int lat,
                        output bit acked, output bit wrong, output logic [31:0] rdat);
    cmd_log.delete();
    @(negedge clk);
    if (ldr) begin
      loader_mem_addr = a; loader_mem_byte_enable = be; loader_mem_write_data = d;
      loader_mem_write_en = 1'b1;
    end else begin
      mcu_mem_addr = a; mcu_mem_byte_enable = be; mcu_mem_write_data = d;
      mcu_mem_write_en = wr; mcu_mem_read_en = ~wr | both;
    end
    lat = 0; acked = 1'b0; wrong = 1'b0; rdat = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if ((ldr ? mcu_ack : loader_ack) === 1'b1) wrong = 1'b1;
      if ((ldr ? loader_ack : mcu_ack) === 1'b1) begin
        acked = 1'b1; rdat = mcu_mem_read_data; break;
      end
      if (i == 0) begin
        loader_mem_addr = 21'($urandom); loader_mem_write_data = $urandom;
        mcu_mem_addr = 21'($urandom); mcu_mem_write_data = $urandom;
        loader_mem_byte_enable = 4'($urandom); mcu_mem_byte_enable = 4'($urandom);
      end
    end
    loader_mem_write_en = 1'b0; mcu_mem_read_en = 1'b0; mcu_mem_write_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [42:0] got;
    reset_n = 1'b0;
    loader_mem_addr = '0; loader_mem_write_en = 1'b0; loader_mem_byte_enable = '0;
    loader_mem_write_data = '0; mcu_mem_addr = '0; mcu_mem_read_en = 1'b0;
    mcu_mem_write_en = 1'b0; mcu_mem_byte_enable = '0; mcu_mem_write_data = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      got = {sd.chipselect, sd.read_n, sd.write_n, sd.byteenable_n, sd.address, sd.writedata};
      n_cmp++;
      if (got !== {1'b0, 1'b1, 1'b1, 2'b11, 22'h0, 16'h0}) begin
        n_err++; $display("FAIL reset_cmd[%0d]: got %h required %h", k, got,
                          {1'b0, 1'b1, 1'b1, 2'b11, 22'h0, 16'h0});
      end
      n_cmp++;
      if ({loader_ack, mcu_ack, mcu_mem_read_data} !== 34'h0) begin
        n_err++; $display("FAIL reset_ack_data[%0d]: got %b %b %h required 0 0 0", k,
                          loader_ack, mcu_ack, mcu_mem_read_data);
      end
      reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_loader_write();
    int lat; bit acked, wrong; logic [31:0] rdat;
    build_exp(1'b1, 21'h000010, 4'hF, 32'hA5A5_1234);
    do_txn(1'b1, 1'b1, 1'b0, 21'h000010, 4'hF, 32'hA5A5_1234, lat, acked, wrong, rdat);
    ref_write(21'h000010, 4'hF, 32'hA5A5_1234);
    n_cmp++;
    if (!acked || wrong) begin n_err++; $display("FAIL loader_ack: acked %0b wrong %0b required 1 0", acked, wrong); end
    n_cmp++;
    if (lat != 3) begin n_err++; $display("FAIL loader_latency: got %0d required 3", lat); end
    n_cmp++;
    if (log_diff() != -1) begin
      n_err++; $display("FAIL loader_cmds: %0d commands, first bad %0d, required %0d", cmd_log.size(), log_diff(), exp_log.size());
    end
    @(negedge clk);
    n_cmp++;
    if (loader_ack !== 1'b0) begin n_err++; $display("FAIL loader_ack_width: got %b required 0", loader_ack); end
  endtask

  task automatic test_half_skip();
    logic [3:0] bes [3];
    int lat; bit acked, wrong; logic [31:0] rdat, d; logic [20:0] a;
    bes[0] = 4'b0011; bes[1] = 4'b0000; bes[2] = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      a = 21'($urandom_range(32, 63)); d = $urandom;
      build_exp(1'b1, a, bes[k], d);
      do_txn(1'b0, 1'b1, 1'b0, a, bes[k], d, lat, acked, wrong, rdat);
      ref_write(a, bes[k], d);
      n_cmp++;
      if (!acked || wrong) begin n_err++; $display("FAIL skip_ack be=%b: acked %0b wrong %0b required 1 0", bes[k], acked, wrong); end
      n_cmp++;
      if (log_diff() != -1) begin
        n_err++; $display("FAIL skip_cmds be=%b: %0d commands, required %0d", bes[k], cmd_log.size(), exp_log.size());
      end
    end
  endtask

  task automatic test_read_stall();
    int lat; bit acked, wrong; logic [31:0] rdat;
    sd_mem[{21'h1, 1'b0}] = 16'h5678; sd_mem[{21'h1, 1'b1}] = 16'h9ABC;
    ref_mem[21'h1] = 32'h9ABC_5678;
    rd_lat = 4; stall_q.delete(); stall_q.push_back(3); stall_q.push_back(0);
    build_exp(1'b0, 21'h1, 4'h0, 32'h0);
    do_txn(1'b0, 1'b0, 1'b0, 21'h1, 4'h0, 32'h0, lat, acked, wrong, rdat);
    n_cmp++;
    if (!acked || wrong) begin n_err++; $display("FAIL read_ack: acked %0b wrong %0b required 1 0", acked, wrong); end
    n_cmp++;
    if (rdat !== ref_read(21'h1)) begin n_err++; $display("FAIL read_data: got %h required %h", rdat, ref_read(21'h1)); end
    n_cmp++;
    if (log_diff() != -1) begin n_err++; $display("FAIL read_cmds: %0d commands, required %0d", cmd_log.size(), exp_log.size()); end
    build_exp(1'b1, 21'h2, 4'hF, 32'h1111_2222);
    do_txn(1'b0, 1'b1, 1'b0, 21'h2, 4'hF, 32'h1111_2222, lat, acked, wrong, rdat);
    ref_write(21'h2, 4'hF, 32'h1111_2222);
    n_cmp++;
    if (rdat !== 32'h9ABC_5678) begin n_err++; $display("FAIL read_data_hold: got %h required 9abc5678", rdat); end
  endtask

  task automatic test_contention();
    bit   grants[$];
    bit   last_mcu, exp_ldr;
    logic [31:0] ld, md;
    pulse_reset();
    ld = $urandom; md = $urandom;
    @(negedge clk);
    loader_mem_addr = 21'h100; loader_mem_byte_enable = 4'hF; loader_mem_write_data = ld;
    mcu_mem_addr = 21'h200; mcu_mem_byte_enable = 4'hF; mcu_mem_write_data = md;
    loader_mem_write_en = 1'b1; mcu_mem_write_en = 1'b1; mcu_mem_read_en = 1'b0;
    for (int i = 0; i < 200 && grants.size() < 3; i++) begin
      @(negedge clk);
      if (loader_ack === 1'b1 && mcu_ack === 1'b1) begin
        n_cmp++; n_err++; $display("FAIL contention_double_ack: both acks high at cycle %0d", i);
      end
      if (loader_ack === 1'b1) grants.push_back(1'b1);
      else if (mcu_ack === 1'b1) grants.push_back(1'b0);
    end
    loader_mem_write_en = 1'b0; mcu_mem_write_en = 1'b0;
    n_cmp++;
    if (grants.size() != 3) begin n_err++; $display("FAIL contention_count: got %0d grants required 3", grants.size()); end
    last_mcu = 1'b1;
    for (int k = 0; k < grants.size(); k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      exp_ldr = last_mcu;
`else
      exp_ldr = 1'b1;
`endif
      last_mcu = ~exp_ldr;
      n_cmp++;
      if (grants[k] !== exp_ldr) begin n_err++; $display("FAIL contention_grant[%0d]: loader=%0b required %0b", k, grants[k], exp_ldr); end
      if (grants[k]) ref_write(21'h100, 4'hF, ld); else ref_write(21'h200, 4'hF, md);
    end
  endtask

  task automatic test_timeout();
    int lat; bit acked, wrong; logic [31:0] rdat, d;
    drop_reads = 1'b1;
    do_txn(1'b0, 1'b0, 1'b0, 21'h3, 4'h0, 32'h0, lat, acked, wrong, rdat);
    drop_reads = 1'b0;
    n_cmp++;
    if (!acked || lat < 256 || lat > 259) begin n_err++; $display("FAIL timeout_latency: acked %0b after %0d cycles required 256..259", acked, lat); end
    n_cmp++;
    if (rdat !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL timeout_data: got %h required deadbeef", rdat); end
    @(negedge clk); inject_late = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mcu_mem_read_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL late_strobe_hold: got %h required deadbeef", mcu_mem_read_data); end
    d = $urandom;
    do_txn(1'b0, 1'b1, 1'b0, 21'h4, 4'hF, d, lat, acked, wrong, rdat);
    ref_write(21'h4, 4'hF, d);
    do_txn(1'b0, 1'b0, 1'b0, 21'h4, 4'h0, 32'h0, lat, acked, wrong, rdat);
    n_cmp++;
    if (!acked || rdat !== ref_read(21'h4)) begin n_err++; $display("FAIL read_after_timeout: got %h required %h", rdat, ref_read(21'h4)); end
  endtask

  task automatic test_reset_mid();
    int lat; bit acked, wrong; logic [31:0] rdat, d;
    logic [20:0] a;
    bit seen;
    a = 21'($urandom_range(64, 127));
    stall_q.delete(); stall_q.push_back(0); stall_q.push_back(20);
    @(negedge clk);
    loader_mem_addr = a; loader_mem_byte_enable = 4'hF; loader_mem_write_data = $urandom;
    loader_mem_write_en = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sd.address !== {a, 1'b1} || sd.chipselect !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_hi: address %h cs %b required %h 1", sd.address, sd.chipselect, {a, 1'b1});
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({sd.chipselect, sd.read_n, sd.write_n, sd.byteenable_n, sd.address, sd.writedata, loader_ack} !==
        {1'b0, 1'b1, 1'b1, 2'b11, 22'h0, 16'h0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_outputs: cs %b wr_n %b be_n %b addr %h required 0 1 11 0",
                        sd.chipselect, sd.write_n, sd.byteenable_n, sd.address);
    end
    loader_mem_write_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (loader_ack === 1'b1 || mcu_ack === 1'b1) seen = 1'b1; end
    stall_q.delete();
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL reset_mid_no_ack: ack seen 1 required 0"); end
    d = $urandom;
    build_exp(1'b1, a, 4'hF, d);
    do_txn(1'b1, 1'b1, 1'b0, a, 4'hF, d, lat, acked, wrong, rdat);
    ref_write(a, 4'hF, d);
    n_cmp++;
    if (!acked || log_diff() != -1) begin n_err++; $display("FAIL reset_mid_recover: acked %0b commands %0d required 1 %0d", acked, cmd_log.size(), exp_log.size()); end
    do_txn(1'b0, 1'b0, 1'b0, a, 4'h0, 32'h0, lat, acked, wrong, rdat);
    n_cmp++;
    if (rdat !== ref_read(a)) begin n_err++; $display("FAIL reset_mid_readback: got %h required %h", rdat, ref_read(a)); end
  endtask

  task automatic test_random();
    int lat; bit acked, wrong, ldr, wr, both; logic [31:0] rdat, d, expd;
    logic [20:0] a; logic [3:0] be;
    for (int n = 0; n < 40; n++) begin
      ldr  = ($urandom_range(0, 2) == 0);
      wr   = ldr | ($urandom_range(0, 1) == 1);
      both = ~ldr & wr & ($urandom_range(0, 3) == 0);
      a = 21'($urandom_range(0, 7)); be = 4'($urandom); d = $urandom;
      rd_lat = $urandom_range(1, 5);
      build_exp(wr, a, be, d);
      stall_q.delete();
      for (int k = 0; k < exp_log.size(); k++) stall_q.push_back($urandom_range(0, 2));
      expd = ref_read(a);
      do_txn(ldr, wr, both, a, be, d, lat, acked, wrong, rdat);
      if (wr) ref_write(a, be, d);
      n_cmp++;
      if (!acked || wrong) begin n_err++; $display("FAIL rand_ack[%0d]: acked %0b wrong %0b required 1 0", n, acked, wrong); end
      n_cmp++;
      if (log_diff() != -1) begin n_err++; $display("FAIL rand_cmds[%0d]: %0d commands first bad %0d required %0d", n, cmd_log.size(), log_diff(), exp_log.size()); end
      if (!wr) begin
        n_cmp++;
        if (rdat !== expd) begin n_err++; $display("FAIL rand_read[%0d]: addr %h got %h required %h", n, a, rdat, expd); end
      end
    end
    stall_q.delete();
    rd_lat = 4;
  endtask

  initial begin
    test_reset();
    test_loader_write();
    test_half_skip();
    test_read_stall();
    test_random();
    test_timeout();
    test_reset_mid();
    test_contention();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sdram_access_arbiter.md
Name: sdram_access_arbiter

Overview:
- Shares the single 16-bit Avalon-MM SDRAM slave port (sdram_slave_*) between two 32-bit word requesters: the hardware loader (write-only) and the MCU data port (read/write).
- Splits each 32-bit access into two 16-bit beats, low half first, and returns a one-cycle ack per request.
- Sits between loader / PulseRain_Rattlesnake_MCU data memory and the SDRAM controller, in the clk_100MHz domain.

Parameters:
- ADDR_BITS, 21, word address width; SDRAM halfword address is {addr, beat}, i.e. ADDR_BITS+1 = 22 bits.
- RD_TIMEOUT, 255, cycles to wait for readdatavalid before abandoning a read.

Ports:
- clk  in  1  clock (clk_100MHz).
- reset_n  in  1  asynchronous active-low reset.
- loader_mem_addr  in  ADDR_BITS  loader word address.
- loader_mem_write_en  in  1  loader write request, level, held until loader_ack.
- loader_mem_byte_enable  in  4  loader byte enables.
- loader_mem_write_data  in  32  loader write data.
- loader_ack  out  1  one-cycle completion pulse.
- mcu_mem_addr  in  ADDR_BITS  MCU word address.
- mcu_mem_read_en  in  1  MCU read request, level, held until mcu_ack.
- mcu_mem_write_en  in  1  MCU write request, level, held until mcu_ack.
- mcu_mem_byte_enable  in  4  MCU byte enables.
- mcu_mem_write_data  in  32  MCU write data.
- mcu_mem_read_data  out  32  read data; valid with mcu_ack on reads, held until the next read completes.
- mcu_ack  out  1  one-cycle completion pulse.
- sdram_slave_address  out  22  halfword address.
- sdram_slave_byteenable_n  out  2  active-low byte enables.
- sdram_slave_chipselect  out  1  command valid.
- sdram_slave_writedata  out  16  write data.
- sdram_slave_read_n  out  1  active-low read.
- sdram_slave_write_n  out  1  active-low write.
- sdram_slave_readdata  in  16  read data.
- sdram_slave_waitrequest  in  1  command stall.
- sdram_slave_readdatavalid  in  1  read data return strobe.

Behaviour:
- Reset values: chipselect=0, read_n=1, write_n=1, byteenable_n=2'b11, address=0, writedata=0, both acks=0, mcu_mem_read_data=0.
- States: IDLE, ISSUE_LO, ISSUE_HI, WAIT_RD, DONE.
- IDLE:
  - Samples requests. Fixed priority: loader over MCU.
  - Latches owner, address, byte enables, data and op.
  - MCU read_en and write_en both high: treated as a write.
  - Transitions to ISSUE_LO.
- ISSUE_LO: drives beat 0 (address {addr,0}, data[15:0], ~be[1:0]). Holds all command outputs while waitrequest=1.
- ISSUE_HI: same for beat 1 (address {addr,1}, data[31:16], ~be[3:2]). Commands are registered outputs.
- Write half-skip: a write beat whose two byte enables are both 0 is skipped. be=4'b0000 goes straight to DONE with no SDRAM command.
- Reads always issue both beats with byteenable_n=2'b00.
- After ISSUE_HI, writes go to DONE and reads go to WAIT_RD.
- Read data collection:
  - A 2-bit counter counts readdatavalid, including strobes arriving during ISSUE_HI.
  - 1st strobe fills read_data[15:0]; 2nd fills [31:16].
  - WAIT_RD exits to DONE on the 2nd strobe.
- DONE: pulses the owner's ack for exactly 1 cycle, then returns to IDLE. A request still asserted in that IDLE cycle is a new request.
- Latency, zero waitrequest:
  - Request seen in IDLE at cycle N; LO command at N+1, HI at N+2.
  - Write: ack at N+3.
  - Read: ack in the cycle after the 2nd readdatavalid.
- Read timeout:
  - Counter starts at ISSUE_HI acceptance.
  - On RD_TIMEOUT cycles without completion: go to DONE, ack, return read_data=32'hDEAD_BEEF.
  - readdatavalid arriving later in IDLE is ignored; the counter is cleared on entry to IDLE.
- Reset mid-operation: asynchronous return to IDLE with reset values; the in-flight transaction is dropped with no ack.
- Request inputs changing while owned: ignored, since the latched copy is used.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requesters pending, grant goes to the requester not granted last. A 1-bit last-grant register resets to MCU, so the first contention goes to the loader.
- Undefined: fixed loader-over-MCU priority; no last-grant register is synthesised.

Test Plan:
- Loader write addr=21'h000010, data=32'hA5A5_1234, be=4'hF, waitrequest=0:
  - Commands {addr,0} data 16'h1234 and {addr,1} data 16'hA5A5, byteenable_n=00.
  - loader_ack 3 cycles after request.
- MCU write be=4'b0011: exactly one SDRAM write, to {addr,0}. be=4'b0000: ack with no command.
- MCU read addr=21'h1: readdatavalid returns 16'h5678 then 16'h9ABC, 4 cycles after each command; waitrequest=1 for 3 cycles on beat 0 with outputs held stable throughout. Required: mcu_mem_read_data=32'h9ABC_5678 with mcu_ack.
- Loader and MCU request in the same cycle, held continuously:
  - Without the macro: loader served every time.
  - With SDRAM_ARB_ROUND_ROBIN_EN: grants alternate loader, MCU, loader.
- Read with no readdatavalid: ack after RD_TIMEOUT=255 cycles, data 32'hDEAD_BEEF. A late strobe afterwards does not corrupt the next read.
- reset_n pulsed low during ISSUE_HI: outputs at reset values immediately, no ack; the next request completes normally.
